// File: rtl/scarv_cop_fu_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// scarv_cop_fu_dispatch_pkg
//   Shared types and constants for the coprocessor functional-unit dispatcher:
//   FSM state encoding, response status codes and functional-unit class
//   indices.
//   No ports (package).
// -----------------------------------------------------------------------------
package scarv_cop_fu_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB,
        ST_RSP
    } state_t;

    typedef enum logic [2:0] {
        RSP_OK        = 3'd0,
        RSP_BAD_CLASS = 3'd1,
        RSP_TIMEOUT   = 3'd2
    } rsp_status_t;

    // Functional-unit class indices (position on fu_ivalid / fu_idone).
    localparam logic [2:0] CLASS_PALU = 3'd0;
    localparam logic [2:0] CLASS_MAU  = 3'd1;
    localparam logic [2:0] CLASS_MEM  = 3'd2;

endpackage

// File: rtl/scarv_cop_fu_dispatch_if.sv
// -----------------------------------------------------------------------------
// scarv_cop_fu_dispatch_if
//   Bundles every dispatcher signal except clock and reset.
//   slave  : dispatcher side (scarv_cop_fu_dispatch)
//   master : environment side (decoder, functional units, CPR file, host CPU)
//   Groups: id_*  decoded instruction in / id_ready out
//           fu_*  operands + one-hot ivalid out, idone/ben/wdata per unit in
//           cpr_* single write-back port out
//           cop_rsp_* status response to CPU
// -----------------------------------------------------------------------------
interface scarv_cop_fu_dispatch_if #(
    parameter int unsigned NUM_FU = 4
);
    logic                    id_valid;
    logic                    id_ready;
    logic [2:0]              id_class;
    logic [3:0]              id_subclass;
    logic [3:0]              id_rd;
    logic [31:0]             id_imm;
    logic [31:0]             id_rs1_data;
    logic [31:0]             id_rs2_data;
    logic [31:0]             id_rs3_data;

    logic [NUM_FU-1:0]       fu_ivalid;
    logic [3:0]              fu_subclass;
    logic [31:0]             fu_imm;
    logic [31:0]             fu_rs1;
    logic [31:0]             fu_rs2;
    logic [31:0]             fu_rs3;
    logic [NUM_FU-1:0]       fu_idone;
    logic [4*NUM_FU-1:0]     fu_rd_ben;
    logic [32*NUM_FU-1:0]    fu_rd_wdata;

    logic                    cpr_rd_wen;
    logic [3:0]              cpr_rd_addr;
    logic [3:0]              cpr_rd_ben;
    logic [31:0]             cpr_rd_wdata;

    logic                    cop_rsp_valid;
    logic                    cop_rsp_ready;
    logic [2:0]              cop_rsp_status;

    modport slave (
        input  id_valid, id_class, id_subclass, id_rd, id_imm,
               id_rs1_data, id_rs2_data, id_rs3_data,
               fu_idone, fu_rd_ben, fu_rd_wdata, cop_rsp_ready,
        output id_ready, fu_ivalid, fu_subclass, fu_imm, fu_rs1, fu_rs2, fu_rs3,
               cpr_rd_wen, cpr_rd_addr, cpr_rd_ben, cpr_rd_wdata,
               cop_rsp_valid, cop_rsp_status
    );

    modport master (
        output id_valid, id_class, id_subclass, id_rd, id_imm,
               id_rs1_data, id_rs2_data, id_rs3_data,
               fu_idone, fu_rd_ben, fu_rd_wdata, cop_rsp_ready,
        input  id_ready, fu_ivalid, fu_subclass, fu_imm, fu_rs1, fu_rs2, fu_rs3,
               cpr_rd_wen, cpr_rd_addr, cpr_rd_ben, cpr_rd_wdata,
               cop_rsp_valid, cop_rsp_status
    );

endinterface

// File: rtl/scarv_cop_fu_result_mux.sv
// -----------------------------------------------------------------------------
// scarv_cop_fu_result_mux
//   Combinational NUM_FU-way selection of one unit's completion, byte enables
//   and write data. Unit i occupies ben_all[4i+3:4i], wdata_all[32i+31:32i].
//   Ports: sel (unit index), idone/ben_all/wdata_all (all units),
//          idone_sel/ben_sel/wdata_sel (selected unit; 0 if sel >= NUM_FU).
// -----------------------------------------------------------------------------
module scarv_cop_fu_result_mux #(
    parameter int unsigned NUM_FU = 4
) (
    input  logic [2:0]           sel,
    input  logic [NUM_FU-1:0]    idone,
    input  logic [4*NUM_FU-1:0]  ben_all,
    input  logic [32*NUM_FU-1:0] wdata_all,
    output logic                 idone_sel,
    output logic [3:0]           ben_sel,
    output logic [31:0]          wdata_sel
);

    always_comb begin
        idone_sel = 1'b0;
        ben_sel   = '0;
        wdata_sel = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (32'(sel) == i) begin
                idone_sel = idone[i];
                ben_sel   = ben_all[4*i +: 4];
                wdata_sel = wdata_all[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/scarv_cop_fu_dispatch.sv
// -----------------------------------------------------------------------------
// scarv_cop_fu_dispatch
//   Issue/write-back sequencer for the coprocessor functional units. Accepts
//   one decoded instruction in IDLE, holds its operands, raises fu_ivalid on
//   the selected unit until idone, performs one CPR write (suppressed for
//   c0 or empty byte enables) and returns a status response to the CPU.
//   Ports: g_clk, g_resetn (async active-low), bus (scarv_cop_fu_dispatch_if
//          slave modport carrying id_*, fu_*, cpr_* and cop_rsp_* groups).
//   Optional: define SCARV_COP_DISPATCH_TIMEOUT_EN to enable an EXEC
//             watchdog of TIMEOUT_CYCLES cycles (status 2 on expiry).
// -----------------------------------------------------------------------------
module scarv_cop_fu_dispatch
    import scarv_cop_fu_dispatch_pkg::*;
#(
    parameter int unsigned NUM_FU         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                     g_clk,
    input logic                     g_resetn,
    scarv_cop_fu_dispatch_if.slave  bus
);

    if (NUM_FU < 1 || NUM_FU > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("scarv_cop_fu_dispatch: NUM_FU must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t      state, state_nxt;
    rsp_status_t status_q, status_nxt;
    logic        accept, capture, timeout_hit;

    logic [2:0]  cls_q;
    logic [3:0]  sub_q, rd_q, ben_q;
    logic [31:0] imm_q, rs1_q, rs2_q, rs3_q, wdata_q;

    logic        idone_sel;
    logic [3:0]  ben_sel;
    logic [31:0] wdata_sel;

    scarv_cop_fu_result_mux #(.NUM_FU(NUM_FU)) u_result_mux (
        .sel       (cls_q),
        .idone     (bus.fu_idone),
        .ben_all   (bus.fu_rd_ben),
        .wdata_all (bus.fu_rd_wdata),
        .idone_sel (idone_sel),
        .ben_sel   (ben_sel),
        .wdata_sel (wdata_sel)
    );

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    // Held at zero outside EXEC, so it reads 0 on the first EXEC cycle.
    logic [15:0] exec_cnt;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)             exec_cnt <= '0;
        else if (state != ST_EXEC) exec_cnt <= '0;
        else                       exec_cnt <= exec_cnt + 16'd1;
    end

    // Fires on the TIMEOUT_CYCLES-th EXEC cycle; idone has priority below.
    assign timeout_hit = (state == ST_EXEC) && (32'(exec_cnt) >= TIMEOUT_CYCLES - 1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.id_valid) begin
                    accept = 1'b1;
                    if (32'(bus.id_class) >= NUM_FU) begin
                        state_nxt  = ST_RSP;
                        status_nxt = RSP_BAD_CLASS;
                    end else begin
                        state_nxt  = ST_EXEC;
                        status_nxt = RSP_OK;
                    end
                end
            end
            ST_EXEC: begin
                if (idone_sel) begin
                    capture   = 1'b1;
                    state_nxt = ST_WB;
                end else if (timeout_hit) begin
                    state_nxt  = ST_RSP;
                    status_nxt = RSP_TIMEOUT;
                end
            end
            ST_WB:   state_nxt = ST_RSP;
            ST_RSP:  if (bus.cop_rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state    <= ST_IDLE;
            status_q <= RSP_OK;
            cls_q    <= '0;
            sub_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
            ben_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            status_q <= status_nxt;
            if (accept) begin
                cls_q <= bus.id_class;
                sub_q <= bus.id_subclass;
                rd_q  <= bus.id_rd;
                imm_q <= bus.id_imm;
                rs1_q <= bus.id_rs1_data;
                rs2_q <= bus.id_rs2_data;
                rs3_q <= bus.id_rs3_data;
            end
            if (capture) begin
                ben_q   <= ben_sel;
                wdata_q <= wdata_sel;
            end
        end
    end

    // Outputs decode from state so an asynchronous reset drops them at once.
    always_comb begin
        bus.fu_ivalid = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            bus.fu_ivalid[i] = (state == ST_EXEC) && (32'(cls_q) == i);
        end
    end

    assign bus.id_ready       = (state == ST_IDLE);
    assign bus.fu_subclass    = sub_q;
    assign bus.fu_imm         = imm_q;
    assign bus.fu_rs1         = rs1_q;
    assign bus.fu_rs2         = rs2_q;
    assign bus.fu_rs3         = rs3_q;

    // c0 is hard-wired zero, so writes to rd=0 never strobe.
    assign bus.cpr_rd_wen     = (state == ST_WB) && (ben_q != 4'd0) && (rd_q != 4'd0);
    assign bus.cpr_rd_addr    = (state == ST_WB) ? rd_q    : '0;
    assign bus.cpr_rd_ben     = (state == ST_WB) ? ben_q   : '0;
    assign bus.cpr_rd_wdata   = (state == ST_WB) ? wdata_q : '0;

    assign bus.cop_rsp_valid  = (state == ST_RSP);
    assign bus.cop_rsp_status = (state == ST_RSP) ? status_q : '0;

endmodule
